// File: rtl/sdram_port_arbiter.sv
// Three-port SDRAM request arbiter. Port 0 (video DMA) has fixed priority.
// Ports 1 (CPU) and 2 (auxiliary) share the remaining slots round-robin.
// A starvation counter forces a port-1/2 grant after STARVE_LIMIT
// consecutive port-0 grants that were made while port 1 or 2 was waiting.
// Each transaction is latched into the ctl_* registers and held until the
// controller acks. The requester is then acked one cycle later.
module sdram_port_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [15:0]       wdata0,
    input  logic [1:0]        bsel0,
    output logic              ack0,

    input  logic              req1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [15:0]       wdata1,
    input  logic [1:0]        bsel1,
    output logic              ack1,

    input  logic              req2,
    input  logic              wr2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [15:0]       wdata2,
    input  logic [1:0]        bsel2,
    output logic              ack2,

    output logic [15:0]       rdata,

    output logic              ctl_req,
    output logic              ctl_wr,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [15:0]       ctl_wdata,
    output logic [1:0]        ctl_bsel,
    input  logic              ctl_ack,
    input  logic [15:0]       ctl_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state, state_nx;
    logic [1:0]        gnt, gnt_nx;
    logic              rr_ptr, rr_ptr_nx;         // 0: port 1 preferred, 1: port 2 preferred
    logic [3:0]        starve_cnt, starve_cnt_nx;

    logic              ctl_req_nx, ctl_wr_nx;
    logic [ADDR_W-1:0] ctl_addr_nx;
    logic [15:0]       ctl_wdata_nx;
    logic [1:0]        ctl_bsel_nx;
    logic              ack0_nx, ack1_nx, ack2_nx;
    logic [15:0]       rdata_nx;

    logic              others_req;
    logic              pick2;
    logic              take0;

    // Winner selection from the sampled request lines
    always_comb begin
        others_req = req1 | req2;
        if (req1 && req2) begin
            pick2 = rr_ptr;
        end else begin
            pick2 = req2;
        end
        take0 = req0 && !(others_req && (starve_cnt == LIMIT));
    end

    // Next-state and next-register-value logic
    always_comb begin
        state_nx      = state;
        gnt_nx        = gnt;
        rr_ptr_nx     = rr_ptr;
        starve_cnt_nx = starve_cnt;
        ctl_req_nx    = ctl_req;
        ctl_wr_nx     = ctl_wr;
        ctl_addr_nx   = ctl_addr;
        ctl_wdata_nx  = ctl_wdata;
        ctl_bsel_nx   = ctl_bsel;
        ack0_nx       = 1'b0;
        ack1_nx       = 1'b0;
        ack2_nx       = 1'b0;
        rdata_nx      = rdata;

        case (state)
            IDLE: begin
                if (req0 || req1 || req2) begin
                    state_nx   = BUSY;
                    ctl_req_nx = 1'b1;
                    if (take0) begin
                        gnt_nx       = 2'd0;
                        ctl_wr_nx    = wr0;
                        ctl_addr_nx  = addr0;
                        ctl_wdata_nx = wdata0;
                        ctl_bsel_nx  = bsel0;
                        if (!others_req) begin
                            starve_cnt_nx = '0;
                        end else if (starve_cnt != LIMIT) begin
                            starve_cnt_nx = starve_cnt + 4'd1;
                        end
                    end else if (pick2) begin
                        gnt_nx        = 2'd2;
                        ctl_wr_nx     = wr2;
                        ctl_addr_nx   = addr2;
                        ctl_wdata_nx  = wdata2;
                        ctl_bsel_nx   = bsel2;
                        rr_ptr_nx     = 1'b0;
                        starve_cnt_nx = '0;
                    end else begin
                        gnt_nx        = 2'd1;
                        ctl_wr_nx     = wr1;
                        ctl_addr_nx   = addr1;
                        ctl_wdata_nx  = wdata1;
                        ctl_bsel_nx   = bsel1;
                        rr_ptr_nx     = 1'b1;
                        starve_cnt_nx = '0;
                    end
                end
            end
            BUSY: begin
                if (ctl_ack) begin
                    state_nx   = DONE;
                    ctl_req_nx = 1'b0;
                    rdata_nx   = ctl_rdata;
                    ack0_nx    = (gnt == 2'd0);
                    ack1_nx    = (gnt == 2'd1);
                    ack2_nx    = (gnt == 2'd2);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            rr_ptr     <= 1'b0;
            starve_cnt <= '0;
            ctl_req    <= 1'b0;
            ctl_wr     <= 1'b0;
            ctl_addr   <= '0;
            ctl_wdata  <= '0;
            ctl_bsel   <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            ack2       <= 1'b0;
            rdata      <= '0;
        end else begin
            state      <= state_nx;
            gnt        <= gnt_nx;
            rr_ptr     <= rr_ptr_nx;
            starve_cnt <= starve_cnt_nx;
            ctl_req    <= ctl_req_nx;
            ctl_wr     <= ctl_wr_nx;
            ctl_addr   <= ctl_addr_nx;
            ctl_wdata  <= ctl_wdata_nx;
            ctl_bsel   <= ctl_bsel_nx;
            ack0       <= ack0_nx;
            ack1       <= ack1_nx;
            ack2       <= ack2_nx;
            rdata      <= rdata_nx;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: single read, round-robin,
// starvation, byte-enabled write, withdrawn request, reset during BUSY.
module tb_sdram_port_arbiter;

    localparam int ADDR_W = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, wr0, req1, wr1, req2, wr2;
    logic [ADDR_W-1:0] addr0, addr1, addr2;
    logic [15:0]       wdata0, wdata1, wdata2;
    logic [1:0]        bsel0, bsel1, bsel2;
    logic              ack0, ack1, ack2;
    logic [15:0]       rdata;
    logic              ctl_req, ctl_wr;
    logic [ADDR_W-1:0] ctl_addr;
    logic [15:0]       ctl_wdata;
    logic [1:0]        ctl_bsel;
    logic              ctl_ack;
    logic [15:0]       ctl_rdata;

    int checks   = 0;
    int failures = 0;

    sdram_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .bsel0(bsel0), .ack0(ack0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .bsel1(bsel1), .ack1(ack1),
        .req2(req2), .wr2(wr2), .addr2(addr2), .wdata2(wdata2), .bsel2(bsel2), .ack2(ack2),
        .rdata(rdata),
        .ctl_req(ctl_req), .ctl_wr(ctl_wr), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
        .ctl_bsel(ctl_bsel), .ctl_ack(ctl_ack), .ctl_rdata(ctl_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] ack_sum();
        return 32'(ack0) + 32'(ack1) + 32'(ack2);
    endfunction

    // Waits for ctl_req, acks after lat cycles, returns the acked port and
    // the number of cycles spent waiting for ctl_req. Returns in the DONE cycle.
    task automatic serve(input int lat, input logic [15:0] rd, output int port, output int waited);
        int n = 0;
        while (!ctl_req && n < 20) begin
            tick();
            n++;
        end
        waited = n;
        port   = -1;
        check("req_wait", 32'(ctl_req), 32'd1);
        if (ctl_req) begin
            repeat (lat) tick();
            ctl_ack   = 1'b1;
            ctl_rdata = rd;
            tick();
            ctl_ack   = 1'b0;
            check("ack_onehot", ack_sum(), 32'd1);
            check("serve_rdata", 32'(rdata), 32'(rd));
            port = ack0 ? 0 : ack1 ? 1 : ack2 ? 2 : -1;
        end
    endtask

    initial begin
        int port, waited;

        reset = 1'b1; ctl_ack = 1'b0; ctl_rdata = '0;
        req0 = 0; wr0 = 0; addr0 = 24'h000A00; wdata0 = 16'h1111; bsel0 = 2'b11;
        req1 = 0; wr1 = 0; addr1 = 24'h000123; wdata1 = 16'h2222; bsel1 = 2'b11;
        req2 = 0; wr2 = 0; addr2 = 24'h00BB00; wdata2 = 16'h3333; bsel2 = 2'b11;

        // Reset state
        do_reset();
        check("rst_ctl_req", 32'(ctl_req), 0);
        check("rst_ctl_wr", 32'(ctl_wr), 0);
        check("rst_ctl_addr", 32'(ctl_addr), 0);
        check("rst_ctl_wdata", 32'(ctl_wdata), 0);
        check("rst_ctl_bsel", 32'(ctl_bsel), 0);
        check("rst_acks", ack_sum(), 0);
        check("rst_rdata", 32'(rdata), 0);

        // Single read from port 1
        req1 = 1'b1;
        tick();
        check("rd_ctl_req", 32'(ctl_req), 1);
        check("rd_ctl_addr", 32'(ctl_addr), 32'h000123);
        check("rd_ctl_wr", 32'(ctl_wr), 0);
        repeat (3) tick();
        check("rd_busy_hold", 32'(ctl_req), 1);
        ctl_ack = 1'b1; ctl_rdata = 16'hBEEF;
        tick();
        ctl_ack = 1'b0; ctl_rdata = 16'h0000;
        check("rd_ack1", 32'(ack1), 1);
        check("rd_ack0", 32'(ack0), 0);
        check("rd_ack2", 32'(ack2), 0);
        check("rd_rdata", 32'(rdata), 32'hBEEF);
        check("rd_req_drop", 32'(ctl_req), 0);
        req1 = 1'b0;
        tick();
        check("rd_ack_clear", ack_sum(), 0);
        check("rd_rdata_hold", 32'(rdata), 32'hBEEF);
        tick();
        check("rd_stay_idle", 32'(ctl_req), 0);

        // Round-robin between ports 1 and 2
        do_reset();
        req1 = 1'b1; req2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            serve(1, 16'(16'h4000 + i), port, waited);
            check($sformatf("rr_grant%0d", i), 32'(port), (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) check($sformatf("rr_spacing%0d", i), 32'(waited), 32'd2);
        end
        req1 = 1'b0; req2 = 1'b0;
        tick();

        // Starvation: port 0 and port 1 both held
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 18; i++) begin
            serve(0, 16'(16'h5000 + i), port, waited);
            check($sformatf("starve_grant%0d", i), 32'(port), (i % 9 == 8) ? 32'd1 : 32'd0);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Byte-enabled write from port 2
        do_reset();
        req2 = 1'b1; wr2 = 1'b1; wdata2 = 16'h55AA; bsel2 = 2'b10;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wr_req%0d", i), 32'(ctl_req), 1);
            check($sformatf("wr_wr%0d", i), 32'(ctl_wr), 1);
            check($sformatf("wr_wdata%0d", i), 32'(ctl_wdata), 32'h55AA);
            check($sformatf("wr_bsel%0d", i), 32'(ctl_bsel), 32'h2);
            check($sformatf("wr_addr%0d", i), 32'(ctl_addr), 32'h00BB00);
            tick();
        end
        ctl_ack = 1'b1;
        tick();
        ctl_ack = 1'b0;
        check("wr_ack2", 32'(ack2), 1);
        check("wr_ack_sum", ack_sum(), 1);
        req2 = 1'b0; wr2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("wr_no_more_ack%0d", i), ack_sum(), 0);
        end

        // Withdrawn request on port 0
        do_reset();
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wd_hold%0d", i), 32'(ctl_req), 1);
            check($sformatf("wd_addr%0d", i), 32'(ctl_addr), 32'h000A00);
            tick();
        end
        ctl_ack = 1'b1; ctl_rdata = 16'h1234;
        tick();
        ctl_ack = 1'b0;
        check("wd_ack0", 32'(ack0), 1);
        check("wd_ack_sum", ack_sum(), 1);
        tick();
        check("wd_ack_clear", ack_sum(), 0);
        check("wd_idle", 32'(ctl_req), 0);

        // Reset while BUSY; late ctl_ack must be ignored
        do_reset();
        req1 = 1'b1;
        tick();
        check("rb_req_up", 32'(ctl_req), 1);
        tick();
        req1 = 1'b0;
        reset = 1'b1;
        tick();
        check("rb_req_reset", 32'(ctl_req), 0);
        check("rb_addr_reset", 32'(ctl_addr), 0);
        reset = 1'b0;
        tick();
        ctl_ack = 1'b1;
        tick();
        ctl_ack = 1'b0;
        check("rb_no_ack", ack_sum(), 0);
        tick();
        check("rb_no_ack_late", ack_sum(), 0);
        check("rb_idle", 32'(ctl_req), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24: word-address width of every port.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: consecutive port-0 grants tolerated while port 1 or 2 waits.
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have, per port x in {0,1,2} (0 = video DMA, 1 = CPU, 2 = auxiliary):
- reqx, input, 1: request.
- wrx, input, 1: 1 = write.
- addrx, input, ADDR_W: word address.
- wdatax, input, 16: write data.
- bselx, input, 2: byte enables, [1] upper.
- ackx, output, 1: one-cycle completion pulse.
REQ-006 SHALL have port rdata, output, 16: read data, valid only while some ackx is high.
REQ-007 SHALL have controller-side ports:
- ctl_req, output, 1.
- ctl_wr, output, 1.
- ctl_addr, output, ADDR_W.
- ctl_wdata, output, 16.
- ctl_bsel, output, 2.
- ctl_ack, input, 1: one-cycle pulse, read data valid.
- ctl_rdata, input, 16.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-009 IDLE: if any reqx is high, SHALL select a winner, latch that port's wr/addr/wdata/bsel into the ctl_* registers, set ctl_req=1, and go to BUSY at the next edge; a request present at edge N gives ctl_req=1 in cycle N+1.
REQ-010 Selection SHALL be: port 0 wins, unless the starvation counter equals STARVE_LIMIT and port 1 or 2 is requesting, in which case the round-robin choice between ports 1 and 2 wins.
REQ-011 When port 0 does not win, SHALL choose between ports 1 and 2 round-robin: the pointer names the preferred port, and after a port-1/2 grant the pointer moves to the other port.
REQ-012 Starvation counter SHALL be 4 bits, saturating at STARVE_LIMIT:
- increments on each port-0 grant made while req1 or req2 is high;
- clears on any port-1/2 grant, or on a port-0 grant with req1 and req2 both low.
REQ-013 BUSY: SHALL hold ctl_req and all latched ctl_* fields stable until ctl_ack is sampled high, then drop ctl_req and go to DONE.
REQ-014 DONE (one cycle): SHALL pulse ackx of the granted port only, drive rdata with ctl_rdata registered at the ctl_ack edge, and return to IDLE.
REQ-015 Minimum spacing SHALL be: ctl_ack at cycle M gives ackx at M+1 and the earliest next ctl_req at M+3, so the acked requester has time to drop req.
REQ-016 SHALL ignore reqx deassertion after grant; the latched transaction completes and is acked.
REQ-017 SHALL ignore ctl_ack in IDLE and DONE.
REQ-018 SHALL keep at most one ackx high per cycle; all ackx SHALL be 0 outside DONE.
REQ-019 rdata SHALL hold its last value outside DONE; it is don't-care for write acks.
REQ-020 Requests changing in the same cycle as a grant decision SHALL be evaluated on sampled values only; no combinational path from reqx to ctl_req.

Reset
REQ-021 reset high at an edge SHALL force, at that edge:
- FSM state = IDLE;
- ctl_req=0, ctl_wr=0, ctl_addr=0, ctl_wdata=0, ctl_bsel=0;
- all ackx=0, rdata=0;
- starvation counter = 0;
- round-robin pointer = port 1.
REQ-022 Reset during BUSY or DONE SHALL abandon the transaction without ackx; a ctl_ack arriving after reset SHALL be ignored.

Verification
REQ-023 Single read: req1=1, wr1=0, addr1=0x000123; controller acks 4 cycles later with ctl_rdata=0xBEEF -> ctl_addr=0x000123 one cycle after req, ack1 one cycle after ctl_ack with rdata=0xBEEF, ack0 and ack2 stay 0.
REQ-024 Round-robin: req1 and req2 held high, req0=0, 6 transactions -> grant order 1,2,1,2,1,2.
REQ-025 Starvation: req0 and req1 held high continuously -> 8 port-0 grants, then 1 port-1 grant, then port 0 again; pattern repeats.
REQ-026 Write with byte enables: req2=1, wr2=1, wdata2=0x55AA, bsel2=2'b10 -> ctl_wr=1, ctl_wdata=0x55AA, ctl_bsel=2'b10 held stable until ctl_ack; ack2 pulses once.
REQ-027 Withdrawn request: req0 drops the cycle after grant -> ctl_req stays high until ctl_ack, ack0 still pulses once.
REQ-028 Reset in BUSY: reset asserted 2 cycles after ctl_req rises, ctl_ack pulsed 1 cycle after reset released -> ctl_req=0 after the reset edge, no ackx pulses, arbiter idle.
